change_dispenser: RTL and testbench

Output stage of the newspaper vending machine. It sits directly downstream of the newspaper coin-accounting FSM and consumes its one-cycle R/N1/D1/D2 strobes. It drives the paper-release, nickel and dime solenoids with timed pulses, one item at a time. It also tracks coin inventory and flags empty hoppers and dropped requests.

---
 rtl/change_dispenser.sv | 176 +++++++++++++++++
 tb/tb_change_dispenser.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: timed paper/nickel/dime solenoid driver with hopper inventory; DISPENSE_STATS_EN builds the paper counter
module change_dispenser #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int CNT_W        = 6,
  parameter int NICKEL_INIT  = 16,
  parameter int DIME_INIT    = 16,
  parameter int LOW_THRESH   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       R,
  input  logic       N1,
  input  logic       D1,
  input  logic       D2,
  input  logic       RELOAD,
  output logic       PAPER,
  output logic       NSOL,
  output logic       DSOL,
  output logic       BUSY,
  output logic       N_LOW,
  output logic       D_LOW,
  output logic       ERR_EMPTY,
  output logic       ERR_OVR,
  output logic [7:0] PAPER_CNT
);
  typedef enum logic [1:0] {IDLE, SELECT, PULSE, GAP} state_t;
  localparam int TW = $clog2((PULSE_CYCLES > GAP_CYCLES ? PULSE_CYCLES : GAP_CYCLES) + 1) + 1;
  localparam logic [TW-1:0] P_LOAD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] G_LOAD = TW'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] N_INIT = CNT_W'(NICKEL_INIT);
  localparam logic [CNT_W-1:0] D_INIT = CNT_W'(DIME_INIT);
  localparam logic [CNT_W:0] LT = (CNT_W + 1)'(LOW_THRESH);
  state_t state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic pp_q, pp_d, np_q, np_d;
  logic [1:0] dp_q, dp_d;
  logic [CNT_W-1:0] n_cnt_q, n_cnt_d, d_cnt_q, d_cnt_d;
  logic err_empty_q, err_empty_d, err_ovr_q, err_ovr_d;
  logic paper_q, paper_d, nsol_q, nsol_d, dsol_q, dsol_d, busy_q, busy_d;
  logic n_low_q, n_low_d, d_low_q, d_low_d;
  logic req, n_ok, d_ok;
  assign req  = R | N1 | D1 | D2;
  assign n_ok = np_q && (n_cnt_q != '0);
  assign d_ok = (dp_q != 2'd0) && (d_cnt_q != '0);
  // next-state, pending work, inventory and registered-output computation
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    pp_d        = pp_q;
    np_d        = np_q;
    dp_d        = dp_q;
    n_cnt_d     = n_cnt_q;
    d_cnt_d     = d_cnt_q;
    err_empty_d = err_empty_q;
    err_ovr_d   = err_ovr_q | ((state_q != IDLE) & req);
    paper_d     = 1'b0;
    nsol_d      = 1'b0;
    dsol_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          pp_d    = R;
          np_d    = N1;
          dp_d    = {D2, D1};
          state_d = SELECT;
        end else if (RELOAD) begin
          n_cnt_d     = N_INIT;
          d_cnt_d     = D_INIT;
          err_empty_d = 1'b0;
        end
      end
      SELECT: begin
        if (pp_q) begin
          pp_d    = 1'b0;
          paper_d = 1'b1;
          tmr_d   = P_LOAD;
          state_d = PULSE;
        end else if (n_ok) begin
          np_d    = 1'b0;
          n_cnt_d = n_cnt_q - 1'b1;
          nsol_d  = 1'b1;
          tmr_d   = P_LOAD;
          state_d = PULSE;
        end else begin
          if (np_q) begin
            np_d        = 1'b0;
            err_empty_d = 1'b1;
          end
          if (d_ok) begin
            dp_d    = dp_q - 2'd1;
            d_cnt_d = d_cnt_q - 1'b1;
            dsol_d  = 1'b1;
            tmr_d   = P_LOAD;
            state_d = PULSE;
          end else begin
            if (dp_q != 2'd0) err_empty_d = 1'b1;
            dp_d    = 2'd0;
            state_d = IDLE;
          end
        end
      end
      PULSE: begin
        paper_d = paper_q && (tmr_q != '0);
        nsol_d  = nsol_q && (tmr_q != '0);
        dsol_d  = dsol_q && (tmr_q != '0);
        tmr_d   = (tmr_q == '0) ? G_LOAD : tmr_q - 1'b1;
        state_d = (tmr_q == '0) ? GAP : PULSE;
      end
      default: begin
        tmr_d   = tmr_q - 1'b1;
        state_d = (tmr_q == '0) ? SELECT : GAP;
      end
    endcase
    busy_d  = state_d != IDLE;
    n_low_d = {1'b0, n_cnt_d} < LT;
    d_low_d = {1'b0, d_cnt_d} < LT;
  end
  // state and output registers, asynchronously cleared to the refilled idle condition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      pp_q        <= 1'b0;
      np_q        <= 1'b0;
      dp_q        <= 2'd0;
      n_cnt_q     <= N_INIT;
      d_cnt_q     <= D_INIT;
      err_empty_q <= 1'b0;
      err_ovr_q   <= 1'b0;
      paper_q     <= 1'b0;
      nsol_q      <= 1'b0;
      dsol_q      <= 1'b0;
      busy_q      <= 1'b0;
      n_low_q     <= {1'b0, N_INIT} < LT;
      d_low_q     <= {1'b0, D_INIT} < LT;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      pp_q        <= pp_d;
      np_q        <= np_d;
      dp_q        <= dp_d;
      n_cnt_q     <= n_cnt_d;
      d_cnt_q     <= d_cnt_d;
      err_empty_q <= err_empty_d;
      err_ovr_q   <= err_ovr_d;
      paper_q     <= paper_d;
      nsol_q      <= nsol_d;
      dsol_q      <= dsol_d;
      busy_q      <= busy_d;
      n_low_q     <= n_low_d;
      d_low_q     <= d_low_d;
    end
  end
  assign PAPER     = paper_q;
  assign NSOL      = nsol_q;
  assign DSOL      = dsol_q;
  assign BUSY      = busy_q;
  assign N_LOW     = n_low_q;
  assign D_LOW     = d_low_q;
  assign ERR_EMPTY = err_empty_q;
  assign ERR_OVR   = err_ovr_q;
`ifdef DISPENSE_STATS_EN
  logic [7:0] pcnt_q, pcnt_d;
  // a paper pulse is issued on every SELECT that still has a paper pending
  always_comb pcnt_d = pcnt_q + 8'((state_q == SELECT) && pp_q);
  // wrapping paper counter, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pcnt_q <= '0;
    else     pcnt_q <= pcnt_d;
  end
  assign PAPER_CNT = pcnt_q;
`else
  assign PAPER_CNT = '0;
`endif
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: scoreboard bench for change_dispenser pulse timing, inventory and error flags
module tb_change_dispenser;
  localparam int P = 4;
  localparam int ITEM = 7;
  typedef struct {int kind; int start;} pulse_t;
  typedef struct {int start; int len;} busy_t;
  logic clk = 1'b0, rst = 1'b1;
  logic R = 0, N1 = 0, D1 = 0, D2 = 0, RELOAD = 0;
  logic PAPER, NSOL, DSOL, BUSY, N_LOW, D_LOW, ERR_EMPTY, ERR_OVR;
  logic [7:0] PAPER_CNT;
  int cyc = 0, n_chk = 0, n_pass = 0;
  int n_inv = 16, d_inv = 16, papers = 0;
  bit err_empty_exp = 0, err_ovr_exp = 0;
  pulse_t exp_p[$];
  busy_t exp_b[$];

  change_dispenser dut (
    .clk(clk), .rst(rst), .R(R), .N1(N1), .D1(D1), .D2(D2), .RELOAD(RELOAD),
    .PAPER(PAPER), .NSOL(NSOL), .DSOL(DSOL), .BUSY(BUSY), .N_LOW(N_LOW), .D_LOW(D_LOW),
    .ERR_EMPTY(ERR_EMPTY), .ERR_OVR(ERR_OVR), .PAPER_CNT(PAPER_CNT)
  );

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // monitor: observes pulses and busy windows at the falling edge, pops expectations
  initial begin
    logic [2:0] sol, prev_sol;
    logic prev_busy;
    int st[3];
    int bst;
    pulse_t e;
    busy_t b;
    prev_sol = '0;
    prev_busy = 1'b0;
    bst = 0;
    forever begin
      @(negedge clk);
      sol = {DSOL, NSOL, PAPER};
      if (rst) begin
        prev_sol = '0;
        prev_busy = 1'b0;
      end else begin
        if (sol != '0) check("onehot", $countones(sol), 1);
        for (int s = 0; s < 3; s++) begin
          if (sol[s] && !prev_sol[s]) st[s] = cyc;
          if (!sol[s] && prev_sol[s]) begin
            if (exp_p.size() == 0) check("pulse_unexpected", s, -1);
            else begin
              e = exp_p.pop_front();
              check("pulse_kind", s, e.kind);
              check("pulse_start", st[s], e.start);
              check("pulse_width", cyc - st[s], P);
            end
          end
        end
        if (BUSY && !prev_busy) bst = cyc;
        if (!BUSY && prev_busy) begin
          if (exp_b.size() == 0) check("busy_unexpected", cyc - bst, -1);
          else begin
            b = exp_b.pop_front();
            check("busy_start", bst, b.start);
            check("busy_len", cyc - bst, b.len);
          end
        end
        prev_sol = sol;
        prev_busy = BUSY;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (BUSY && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", BUSY, 0);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_nlow"}, N_LOW, int'(n_inv < 3));
    check({tag, "_dlow"}, D_LOW, int'(d_inv < 3));
    check({tag, "_erre"}, ERR_EMPTY, err_empty_exp);
    check({tag, "_erro"}, ERR_OVR, err_ovr_exp);
  endtask

  // model the dispense sequence, push expectations, then drive a one-cycle request
  task automatic push_req(input bit r, input bit n1, input bit d1, input bit d2, input int k);
    int t, n;
    t = k + 1;
    n = 0;
    if (r) begin exp_p.push_back('{0, t}); t += ITEM; n++; papers++; end
    if (n1) begin
      if (n_inv > 0) begin exp_p.push_back('{1, t}); t += ITEM; n++; n_inv--; end
      else err_empty_exp = 1;
    end
    for (int i = 0; i < int'(d1) + 2 * int'(d2); i++) begin
      if (d_inv > 0) begin exp_p.push_back('{2, t}); t += ITEM; n++; d_inv--; end
      else begin err_empty_exp = 1; break; end
    end
    exp_b.push_back('{k, 1 + ITEM * n});
  endtask

  task automatic send(input bit r, input bit n1, input bit d1, input bit d2);
    @(negedge clk);
    push_req(r, n1, d1, d2, cyc + 1);
    R = r; N1 = n1; D1 = d1; D2 = d2;
    @(negedge clk);
    R = 0; N1 = 0; D1 = 0; D2 = 0;
    wait_idle();
  endtask

  task automatic reload();
    @(negedge clk);
    RELOAD = 1;
    @(negedge clk);
    RELOAD = 0;
    n_inv = 16;
    d_inv = 16;
    err_empty_exp = 0;
  endtask

  task automatic model_reset();
    n_inv = 16; d_inv = 16; papers = 0;
    err_empty_exp = 0; err_ovr_exp = 0;
    exp_p.delete();
    exp_b.delete();
  endtask

  initial begin
    int k, n;
    bit r, n1, d1, d2;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rst_paper", PAPER, 0);
    check("rst_nsol", NSOL, 0);
    check("rst_dsol", DSOL, 0);
    check("rst_busy", BUSY, 0);
    check("rst_pcnt", PAPER_CNT, 0);
    check_flags("rst");

    send(1, 0, 0, 0);
    check_flags("t1");
    send(1, 1, 1, 0);
    check_flags("t2");

    @(negedge clk);
    k = cyc + 1;
    exp_p.push_back('{1, k + 1});
    exp_b.push_back('{k, 8});
    n_inv--;
    N1 = 1;
    @(negedge clk);
    N1 = 0;
    repeat (2) @(negedge clk);
    D1 = 1;
    @(negedge clk);
    D1 = 0;
    err_ovr_exp = 1;
    check("ovr_flag", ERR_OVR, 1);
    wait_idle();
    check_flags("t4");

    repeat (7) send(0, 0, 0, 1);
    check_flags("drain");
    send(1, 0, 0, 1);
    check_flags("t3");
    reload();
    check_flags("reload1");

    for (int i = 0; i < 40; i++) begin
      {r, n1, d1, d2} = 4'($urandom_range(1, 15));
      send(r, n1, d1, d2);
    end
    check_flags("rand");
    reload();
    check_flags("reload2");

    @(negedge clk);
    D2 = 1;
    @(negedge clk);
    D2 = 0;
    n = 0;
    while (!DSOL && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("dsol_seen", DSOL, 1);
    @(posedge clk);
    #2 rst = 1;
    #1;
    check("arst_paper", PAPER, 0);
    check("arst_nsol", NSOL, 0);
    check("arst_dsol", DSOL, 0);
    check("arst_busy", BUSY, 0);
    check("arst_erro", ERR_OVR, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    send(1, 0, 0, 0);
    check_flags("t5");

    for (int i = 0; i < 255; i++) send(1, 0, 0, 0);
`ifdef DISPENSE_STATS_EN
    check("pcnt_256", PAPER_CNT, papers % 256);
`else
    check("pcnt_off", PAPER_CNT, 0);
`endif
    send(1, 0, 0, 0);
`ifdef DISPENSE_STATS_EN
    check("pcnt_257", PAPER_CNT, papers % 256);
`else
    check("pcnt_off2", PAPER_CNT, 0);
`endif
    repeat (3) @(negedge clk);
    check("pulses_left", exp_p.size(), 0);
    check("busy_left", exp_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
